// File: rtl/word_serializer_lsb_pkg.sv
// word_serializer_lsb_pkg: shared serial-stage state encoding and default word width
package word_serializer_lsb_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;
  localparam int SER_WIDTH = 8;
endpackage

// File: rtl/word_serializer_lsb.sv
// word_serializer_lsb: valid/ready parallel-to-serial front end, LSB first with word-boundary markers
// Ports: clk_in/rst_in (async active-high reset); data_in/valid_in/ready_out accept a WIDTH-bit word;
// bit_out is the serial stream, first_out/last_out flag bit 0 / bit WIDTH-1, busy_out flags a word in flight.
module word_serializer_lsb
  import word_serializer_lsb_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             bit_out,
  output logic             first_out,
  output logic             last_out,
  output logic             busy_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  ser_state_t       r_state, w_state_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [WIDTH-1:0] r_sr, w_sr_next;
  logic             w_shift, w_last, w_accept;
  assign w_shift  = r_state == SHIFT;
  assign w_last   = w_shift && r_cnt == LAST;
  // ready depends only on state and counter so there is no valid->ready loop
  assign w_accept = valid_in && (!w_shift || w_last);
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_sr    <= w_sr_next;
    end
  end
  // a last-bit accept reloads in place, giving back-to-back words with no gap
  always_comb begin
    w_state_next = w_accept ? SHIFT : (w_last ? IDLE : r_state);
    w_cnt_next   = (w_accept || w_last) ? '0 : (w_shift ? r_cnt + CW'(1) : r_cnt);
    w_sr_next    = w_accept ? data_in : (w_shift ? r_sr >> 1 : r_sr);
  end
  always_comb begin
    ready_out = !w_shift || w_last;
    bit_out   = w_shift && r_sr[0];
    first_out = w_shift && r_cnt == '0;
    last_out  = w_last;
    busy_out  = w_shift;
  end
endmodule
